// File: rtl/force_override_unit.sv
// force_override_unit: per-channel force/release override point between drivers and consumers.
// Optional auto-release hold counters are built when FORCE_OVR_AUTOREL_EN is defined.
module force_override_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CHW   = $clog2(NCH) + 1,
  parameter int unsigned CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHW-1:0]       cmd_ch,
  input  logic [WIDTH-1:0]     cmd_value,
  input  logic [CNTW-1:0]      cmd_hold,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 rsp_forced,
  output logic                 rsp_err,
  input  logic [NCH*WIDTH-1:0] drv_in,
  output logic [NCH*WIDTH-1:0] net_out,
  output logic [NCH-1:0]       forced_mask
);

  localparam int unsigned IdxW = $clog2(NCH);

  localparam logic [1:0] OpQuery      = 2'b00;
  localparam logic [1:0] OpForce      = 2'b01;
  localparam logic [1:0] OpRelease    = 2'b10;
  localparam logic [1:0] OpReleaseAll = 2'b11;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e                    state_q, state_d;
  logic [NCH-1:0]            forced_q, forced_d;
  logic [NCH-1:0][WIDTH-1:0] fval_q, fval_d;
  logic [WIDTH-1:0]          rsp_data_q, rsp_data_d;
  logic                      rsp_forced_q, rsp_forced_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NCH-1:0][WIDTH-1:0] drv;
  logic [NCH-1:0][WIDTH-1:0] net;
  logic [IdxW-1:0]           idx;
  logic                      ch_ok;
  logic                      accept;

`ifdef FORCE_OVR_AUTOREL_EN
  logic [NCH-1:0][CNTW-1:0]  cnt_q, cnt_d;
`else
  logic                      unused_hold;
  assign unused_hold = ^cmd_hold;
`endif

  assign drv    = drv_in;
  assign idx    = cmd_ch[IdxW-1:0];
  assign ch_ok  = (32'(cmd_ch) < NCH);
  assign accept = (state_q == StIdle) && cmd_valid;

  // Forced channels show the held value; all others pass the live driver through.
  always_comb begin
    net = drv;
    for (int c = 0; c < NCH; c++) begin
      if (forced_q[c]) begin
        net[c] = fval_q[c];
      end
    end
  end

  assign net_out     = net;
  assign forced_mask = forced_q;
  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign rsp_data    = rsp_data_q;
  assign rsp_forced  = rsp_forced_q;
  assign rsp_err     = rsp_err_q;

  always_comb begin
    state_d      = state_q;
    forced_d     = forced_q;
    fval_d       = fval_q;
    rsp_data_d   = rsp_data_q;
    rsp_forced_d = rsp_forced_q;
    rsp_err_d    = rsp_err_q;
`ifdef FORCE_OVR_AUTOREL_EN
    cnt_d        = cnt_q;
    // Expiry is applied first so an accepted command on the same edge overrides it.
    for (int c = 0; c < NCH; c++) begin
      if (cnt_q[c] != '0) begin
        cnt_d[c] = cnt_q[c] - CNTW'(1);
        if (cnt_q[c] == CNTW'(1)) begin
          forced_d[c] = 1'b0;
        end
      end
    end
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StResp;
          rsp_data_d   = '0;
          rsp_forced_d = 1'b0;
          rsp_err_d    = 1'b0;
          unique case (cmd_op)
            OpQuery: begin
              if (ch_ok) begin
                rsp_data_d   = net[idx];
                rsp_forced_d = forced_q[idx];
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            OpForce: begin
              if (ch_ok) begin
                forced_d[idx] = 1'b1;
                fval_d[idx]   = cmd_value;
`ifdef FORCE_OVR_AUTOREL_EN
                cnt_d[idx]    = cmd_hold;
`endif
                rsp_data_d    = cmd_value;
                rsp_forced_d  = 1'b1;
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            OpRelease: begin
              if (ch_ok) begin
                forced_d[idx] = 1'b0;
`ifdef FORCE_OVR_AUTOREL_EN
                cnt_d[idx]    = '0;
`endif
                rsp_data_d    = drv[idx];
              end else begin
                rsp_err_d = 1'b1;
              end
            end
            OpReleaseAll: begin
              forced_d = '0;
`ifdef FORCE_OVR_AUTOREL_EN
              cnt_d    = '0;
`endif
              // Out-of-range channel is not an error here; data simply reads as zero.
              if (ch_ok) begin
                rsp_data_d = drv[idx];
              end
            end
          endcase
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      forced_q     <= '0;
      fval_q       <= '0;
      rsp_data_q   <= '0;
      rsp_forced_q <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef FORCE_OVR_AUTOREL_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      forced_q     <= forced_d;
      fval_q       <= fval_d;
      rsp_data_q   <= rsp_data_d;
      rsp_forced_q <= rsp_forced_d;
      rsp_err_q    <= rsp_err_d;
`ifdef FORCE_OVR_AUTOREL_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_force_override_unit.sv
// Testbench for force_override_unit: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model (auto-release with FORCE_OVR_AUTOREL_EN).
`timescale 1ns/1ps
module tb_force_override_unit;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CHW   = $clog2(NCH) + 1;
  localparam int CNTW  = 8;

  localparam logic [1:0] OP_Q  = 2'b00;
  localparam logic [1:0] OP_F  = 2'b01;
  localparam logic [1:0] OP_R  = 2'b10;
  localparam logic [1:0] OP_RA = 2'b11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_op = 2'b00;
  logic [CHW-1:0]       cmd_ch = '0;
  logic [WIDTH-1:0]     cmd_value = '0;
  logic [CNTW-1:0]      cmd_hold = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [WIDTH-1:0]     rsp_data;
  logic                 rsp_forced;
  logic                 rsp_err;
  logic [NCH*WIDTH-1:0] drv_in = '0;
  logic [NCH*WIDTH-1:0] net_out;
  logic [NCH-1:0]       forced_mask;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  int cyc      = 0;

  always #5 clk = ~clk;

  force_override_unit #(
    .WIDTH(WIDTH),
    .NCH  (NCH),
    .CHW  (CHW),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_ch     (cmd_ch),
    .cmd_value  (cmd_value),
    .cmd_hold   (cmd_hold),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_forced (rsp_forced),
    .rsp_err    (rsp_err),
    .drv_in     (drv_in),
    .net_out    (net_out),
    .forced_mask(forced_mask)
  );

  // Behavioural model: forced set, held values, absolute expiry cycle per channel.
  bit               m_busy = 1'b0;
  logic [NCH-1:0]   m_forced = '0;
  logic [WIDTH-1:0] m_fval [NCH];
  int               m_expire [NCH];
  logic [WIDTH-1:0] m_rdata = '0;
  bit               m_rforced = 1'b0;
  bit               m_rerr = 1'b0;
  int               ch_i;
  bit               ok;
  bit               acc;

  function automatic logic [WIDTH-1:0] drv_ch(int c);
    return drv_in[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] net_ch(int c);
    return net_out[c*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] exp_net(int c);
    return m_forced[c] ? m_fval[c] : drv_ch(c);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    = 1'b0;
      m_forced  = '0;
      m_rdata   = '0;
      m_rforced = 1'b0;
      m_rerr    = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_fval[c]   = '0;
        m_expire[c] = -1;
      end
    end else begin
      cyc++;
      ch_i = int'(cmd_ch);
      ok   = ch_i < NCH;
      acc  = !m_busy && cmd_valid;
      if (acc) begin
        m_rdata   = '0;
        m_rforced = 1'b0;
        m_rerr    = 1'b0;
        if (!ok && cmd_op != OP_RA) begin
          m_rerr = 1'b1;
        end else if (ok) begin
          case (cmd_op)
            OP_Q: begin
              m_rdata   = exp_net(ch_i);
              m_rforced = m_forced[ch_i];
            end
            OP_F: begin
              m_rdata   = cmd_value;
              m_rforced = 1'b1;
            end
            default: m_rdata = drv_ch(ch_i);
          endcase
        end
      end
`ifdef FORCE_OVR_AUTOREL_EN
      for (int c = 0; c < NCH; c++) begin
        if (m_expire[c] == cyc) m_forced[c] = 1'b0;
      end
`endif
      if (acc) begin
        if (cmd_op == OP_RA) begin
          m_forced = '0;
          for (int c = 0; c < NCH; c++) m_expire[c] = -1;
        end else if (ok && cmd_op == OP_F) begin
          m_forced[ch_i] = 1'b1;
          m_fval[ch_i]   = cmd_value;
          m_expire[ch_i] = (cmd_hold == 0) ? -1 : cyc + int'(cmd_hold);
        end else if (ok && cmd_op == OP_R) begin
          m_forced[ch_i] = 1'b0;
          m_expire[ch_i] = -1;
        end
        m_busy = 1'b1;
      end else if (m_busy && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmd_ready", cmd_ready, !m_busy);
      check("rsp_valid", rsp_valid, m_busy);
      check("forced_mask", forced_mask, m_forced);
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("net_out[%0d]", c), net_ch(c), exp_net(c));
      end
      if (m_busy) begin
        check("rsp_data", rsp_data, m_rdata);
        check("rsp_forced", rsp_forced, m_rforced);
        check("rsp_err", rsp_err, m_rerr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_drv(int c, logic [WIDTH-1:0] v);
    drv_in[c*WIDTH +: WIDTH] = v;
  endtask

  // Drives one command for one edge; the unit must be idle when called.
  task automatic issue(logic [1:0] op, int ch, logic [WIDTH-1:0] v, int h);
    check("issue_cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = CHW'(ch);
    cmd_value = v;
    cmd_hold  = CNTW'(h);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    drv_in = (NCH*WIDTH)'($urandom);
    rst    = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_forced", rsp_forced, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_forced_mask", forced_mask, 4'b0000);
    check("rst_net_out", net_out, drv_in);
    tick();
    rst = 1'b0;
    tick();

    // Release after force
    set_drv(1, 8'h11);
    issue(OP_F, 1, 8'h01, 0);
    @(negedge clk);
    check("f1_net1", net_ch(1), 8'h01);
    check("f1_mask", forced_mask, 4'b0010);
    check("f1_rsp_data", rsp_data, 8'h01);
    check("f1_rsp_forced", rsp_forced, 1'b1);
    tick();
    issue(OP_R, 1, 8'h00, 0);
    @(negedge clk);
    check("r1_net1", net_ch(1), 8'h11);
    check("r1_rsp_data", rsp_data, 8'h11);
    check("r1_rsp_forced", rsp_forced, 1'b0);
    check("r1_mask", forced_mask, 4'b0000);
    tick();

    // Independent channels
    set_drv(0, 8'h33);
    issue(OP_F, 1, 8'h01, 0);
    tick();
    issue(OP_F, 0, 8'h10, 0);
    @(negedge clk);
    check("ind_net0", net_ch(0), 8'h10);
    check("ind_net1", net_ch(1), 8'h01);
    tick();
    issue(OP_R, 0, 8'h00, 0);
    @(negedge clk);
    check("ind_rel_net0", net_ch(0), 8'h33);
    check("ind_rel_net1", net_ch(1), 8'h01);
    tick();
    issue(OP_RA, 0, 8'h00, 0);
    @(negedge clk);
    check("ra_net", net_out, drv_in);
    check("ra_mask", forced_mask, 4'b0000);
    check("ra_rsp_data", rsp_data, 8'h33);
    tick();

    // Backpressure with a queued command
    rsp_ready = 1'b0;
    issue(OP_F, 2, 8'hA5, 0);
    cmd_valid = 1'b1;
    cmd_op    = OP_Q;
    cmd_ch    = CHW'(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data", rsp_data, 8'hA5);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_last_cmd_ready", cmd_ready, 1'b0);
    tick();
    @(negedge clk);
    check("bp_after_cmd_ready", cmd_ready, 1'b1);
    check("bp_after_rsp_valid", rsp_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("bp_q_rsp_data", rsp_data, 8'hA5);
    check("bp_q_rsp_forced", rsp_forced, 1'b1);
    tick();

    // Error and pass-through
    issue(OP_F, NCH, 8'h77, 0);
    @(negedge clk);
    check("err_rsp_err", rsp_err, 1'b1);
    check("err_rsp_data", rsp_data, 8'h00);
    check("err_rsp_forced", rsp_forced, 1'b0);
    check("err_mask", forced_mask, 4'b0100);
    tick();
    set_drv(3, 8'h00);
    issue(OP_Q, 3, 8'h00, 0);
    @(negedge clk);
    check("pt_rsp_data", rsp_data, 8'h00);
    check("pt_rsp_forced", rsp_forced, 1'b0);
    #2 set_drv(3, 8'hFF);
    #1 check("pt_net3", net_ch(3), 8'hFF);
    tick();

    // Reset with a pending response and active forces
    rsp_ready = 1'b0;
    issue(OP_F, 0, 8'h5A, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_mask", forced_mask, 4'b0000);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check("mid_rst_net", net_out, drv_in);
    tick();
    rst       = 1'b0;
    rsp_ready = 1'b1;
    tick();

`ifdef FORCE_OVR_AUTOREL_EN
    set_drv(1, 8'h11);
    issue(OP_F, 1, 8'h01, 3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("ar_held_%0d", k), net_ch(1), 8'h01);
      tick();
    end
    @(negedge clk);
    check("ar_expired_net1", net_ch(1), 8'h11);
    check("ar_expired_mask", forced_mask, 4'b0000);
    tick();
    issue(OP_F, 1, 8'h01, 0);
    repeat (100) tick();
    @(negedge clk);
    check("ar_h0_mask", forced_mask, 4'b0010);
    check("ar_h0_net1", net_ch(1), 8'h01);
    tick();
    issue(OP_RA, 1, 8'h00, 0);
    tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_ch    = ($urandom_range(0, 5) == 0) ? CHW'($urandom_range(NCH, (1 << CHW) - 1))
                                              : CHW'($urandom_range(0, NCH - 1));
      cmd_value = WIDTH'($urandom);
      cmd_hold  = ($urandom_range(0, 3) == 0) ? '0 : CNTW'($urandom_range(1, 6));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) set_drv($urandom_range(0, NCH - 1), WIDTH'($urandom));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
